cache_mem_arb: RTL and testbench

//  Sequences and shares the single mem_ctrl line port between i_cache refills and d_cache refill/writeback.

---
 rtl/cache_arb_pkg.sv | 19 +
 rtl/cache_mem_arb.sv | 191 +++++++++++++++++++
 tb/tb_cache_mem_arb.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_arb_pkg.sv
// Shared types for the cache-to-memory line-port arbiter.
package cache_arb_pkg;
    localparam int DEF_LINE_WORDS = 16;
    localparam int LINE_BITS      = 32 * DEF_LINE_WORDS;

    typedef logic [LINE_BITS-1:0] line_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_t;
endpackage

// File: rtl/cache_mem_arb.sv
// Shares the single mem_ctrl line port between I-side refills and D-side refill/writeback.
// Define CACHE_ARB_TIMEOUT_EN to abort a WAIT lasting TIMEOUT cycles, pulsing err with done.
module cache_mem_arb #(
    parameter int LINE_WORDS = cache_arb_pkg::DEF_LINE_WORDS,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_req,
    input  logic [31:0]             i_addr,
    output logic                    i_gnt,
    output logic                    i_done,
    output logic [32*LINE_WORDS-1:0] i_rdata,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [31:0]             d_addr,
    input  logic [32*LINE_WORDS-1:0] d_wdata,
    output logic                    d_gnt,
    output logic                    d_done,
    output logic [32*LINE_WORDS-1:0] d_rdata,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [31:0]             mem_addr,
    output logic [32*LINE_WORDS-1:0] mem_wdata,
    input  logic [32*LINE_WORDS-1:0] mem_rdata,
    input  logic                    ready,
    input  logic                    tx_done,
    output logic                    err
);
    import cache_arb_pkg::*;

    localparam int LB = 32 * LINE_WORDS;
    localparam int SW = $clog2(STARVE_MAX + 1) + 1;

    arb_state_t    state_q, state_d;
    owner_t        owner_q, owner_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          i_gnt_q, i_gnt_d, d_gnt_q, d_gnt_d;
    logic          i_done_q, i_done_d, d_done_q, d_done_d;
    logic          mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [LB-1:0] mem_wdata_q, mem_wdata_d;
    logic [LB-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
`ifdef CACHE_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT) + 1;
    logic [TW-1:0] wait_cnt_q, wait_cnt_d;
    logic          err_q, err_d;
`endif

    // Line offset bits never reach memory; the line address is always aligned.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[5:0], d_addr[5:0]};

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        starve_d    = starve_q;
        i_gnt_d     = i_gnt_q;
        d_gnt_d     = d_gnt_q;
        i_done_d    = 1'b0;
        d_done_d    = 1'b0;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
`ifdef CACHE_ARB_TIMEOUT_EN
        err_d       = 1'b0;
        wait_cnt_d  = wait_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (!i_req) starve_d = '0;
                if (d_req || i_req) begin
                    state_d   = ISSUE;
                    mem_req_d = 1'b1;
                    // D wins ties unless I has already watched STARVE_MAX D grants go by.
                    if (d_req && !(i_req && starve_q == SW'(STARVE_MAX))) begin
                        owner_d     = OWN_D;
                        d_gnt_d     = 1'b1;
                        mem_we_d    = d_we;
                        mem_addr_d  = {d_addr[31:6], 6'b0};
                        mem_wdata_d = d_wdata;
                        if (i_req) starve_d = starve_q + SW'(1);
                    end else begin
                        owner_d    = OWN_I;
                        i_gnt_d    = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = {i_addr[31:6], 6'b0};
                        starve_d   = '0;
                    end
                end
            end
            ISSUE: begin
                if (ready) begin
                    mem_req_d = 1'b0;
                    state_d   = WAIT;
`ifdef CACHE_ARB_TIMEOUT_EN
                    wait_cnt_d = '0;
`endif
                end
            end
            WAIT: begin
                if (tx_done) begin
                    state_d = RESP;
                    if (owner_q == OWN_D) begin
                        d_done_d = 1'b1;
                        if (!mem_we_q) d_rdata_d = mem_rdata;
                    end else begin
                        i_done_d  = 1'b1;
                        i_rdata_d = mem_rdata;
                    end
                end
`ifdef CACHE_ARB_TIMEOUT_EN
                else if (wait_cnt_q == TW'(TIMEOUT - 1)) begin
                    state_d  = RESP;
                    err_d    = 1'b1;
                    d_done_d = (owner_q == OWN_D);
                    i_done_d = (owner_q == OWN_I);
                end else begin
                    wait_cnt_d = wait_cnt_q + TW'(1);
                end
`endif
            end
            RESP: begin
                state_d = IDLE;
                i_gnt_d = 1'b0;
                d_gnt_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= OWN_I;
            starve_q    <= '0;
            i_gnt_q     <= 1'b0;
            d_gnt_q     <= 1'b0;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
`ifdef CACHE_ARB_TIMEOUT_EN
            wait_cnt_q  <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            starve_q    <= starve_d;
            i_gnt_q     <= i_gnt_d;
            d_gnt_q     <= d_gnt_d;
            i_done_q    <= i_done_d;
            d_done_q    <= d_done_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
`ifdef CACHE_ARB_TIMEOUT_EN
            wait_cnt_q  <= wait_cnt_d;
            err_q       <= err_d;
`endif
        end
    end

    assign i_gnt     = i_gnt_q;
    assign d_gnt     = d_gnt_q;
    assign i_done    = i_done_q;
    assign d_done    = d_done_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
`ifdef CACHE_ARB_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_cache_mem_arb.sv
// Bench for cache_mem_arb: directed scenarios plus randomized traffic, all checked
// against a transaction-milestone reference model of the arbiter.
module tb_cache_mem_arb;
    import cache_arb_pkg::*;

    localparam int TB_STARVE  = 4;
    localparam int TB_TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, d_req, d_we, ready, tx_done;
    logic [31:0] i_addr, d_addr;
    line_t       d_wdata, mem_rdata;
    logic        i_gnt, i_done, d_gnt, d_done, mem_req, mem_we, err;
    logic [31:0] mem_addr;
    line_t       i_rdata, d_rdata, mem_wdata;

    always #5 clk = ~clk;

    cache_mem_arb #(
        .LINE_WORDS(DEF_LINE_WORDS),
        .STARVE_MAX(TB_STARVE),
        .TIMEOUT   (TB_TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_gnt    (i_gnt),
        .i_done   (i_done),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_done   (d_done),
        .d_rdata  (d_rdata),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .ready    (ready),
        .tx_done  (tx_done),
        .err      (err)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: a transaction is granted, accepted by memory, then answered.
    bit          m_busy, m_own_d, m_acc, m_resp, m_err, m_we;
    int          m_starve, m_wait;
    logic [31:0] m_addr;
    line_t       m_wdata, m_irdata, m_drdata;

    task automatic checkOutput(input string tag, input line_t got, input line_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic line_t randLine();
        line_t l;
        for (int w = 0; w < DEF_LINE_WORDS; w++) l[32*w +: 32] = $urandom;
        return l;
    endfunction

    task automatic modelReset();
        m_busy = 0; m_own_d = 0; m_acc = 0; m_resp = 0; m_err = 0; m_we = 0;
        m_starve = 0; m_wait = 0; m_addr = '0; m_wdata = '0; m_irdata = '0; m_drdata = '0;
    endtask

    // Advance the model by one clock using the inputs the DUT saw at that edge.
    task automatic modelStep();
        if (!rst_n) begin
            modelReset();
        end else if (m_resp) begin
            m_resp = 0; m_err = 0; m_busy = 0;
        end else if (!m_busy) begin
            if (!i_req) m_starve = 0;
            if (i_req || d_req) begin
                m_own_d = d_req && !(i_req && m_starve >= TB_STARVE);
                if (m_own_d) begin
                    m_addr = d_addr & 32'hffff_ffc0;
                    m_we = d_we;
                    m_wdata = d_wdata;
                    if (i_req) m_starve = m_starve + 1;
                end else begin
                    m_addr = i_addr & 32'hffff_ffc0;
                    m_we = 0;
                    m_starve = 0;
                end
                m_busy = 1; m_acc = 0;
            end
        end else if (!m_acc) begin
            if (ready) begin m_acc = 1; m_wait = 0; end
        end else if (tx_done) begin
            if (!m_own_d) m_irdata = mem_rdata;
            else if (!m_we) m_drdata = mem_rdata;
            m_resp = 1;
        end else begin
`ifdef CACHE_ARB_TIMEOUT_EN
            m_wait = m_wait + 1;
            if (m_wait == TB_TIMEOUT) begin m_resp = 1; m_err = 1; end
`endif
        end
    endtask

    task automatic checkAll();
        checkOutput("ctrl", {i_gnt, d_gnt, i_done, d_done, mem_req, err},
                    {m_busy && !m_own_d, m_busy && m_own_d, m_resp && !m_own_d,
                     m_resp && m_own_d, m_busy && !m_acc, m_err});
        checkOutput("mem_addr", mem_addr, m_addr);
        checkOutput("mem_we", mem_we, m_we);
        if (m_busy && !m_acc && m_we) checkOutput("mem_wdata", mem_wdata, m_wdata);
        checkOutput("i_rdata", i_rdata, m_irdata);
        checkOutput("d_rdata", d_rdata, m_drdata);
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
        modelStep();
        checkAll();
    endtask

    task automatic runUntilDone(input string tag, output bit got_d);
        bit seen = 0;
        got_d = 0;
        for (int k = 0; k < 60 && !seen; k++) begin
            stepCycle();
            if (i_done || d_done) begin seen = 1; got_d = d_done; end
        end
        if (!seen) checkOutput({tag, "_budget"}, 1'b0, 1'b1);
    endtask

    // Random requesters hold req until done; memory side answers at random.
    task automatic applyStimulus();
        if (i_done || !i_req) begin
            i_req = ($urandom_range(3) == 0);
            i_addr = $urandom;
        end else if ($urandom_range(3) == 0) begin
            i_addr = $urandom;
        end
        if (d_done || !d_req) begin
            d_req = ($urandom_range(2) == 0);
            d_we = $urandom_range(1);
            d_addr = $urandom;
            d_wdata = randLine();
        end else if ($urandom_range(3) == 0) begin
            d_we = $urandom_range(1);
            d_addr = $urandom;
            d_wdata = randLine();
        end
        ready = $urandom_range(1);
        tx_done = ($urandom_range(3) == 0);
        mem_rdata = randLine();
        rst_n = ($urandom_range(199) != 0);
    endtask

    initial begin
        bit    got_d, seen;
        int    edges, cnt;
        line_t line_a, incr, prev_d;

        rst_n = 0; i_req = 0; d_req = 0; d_we = 0; ready = 0; tx_done = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        modelReset();
        stepCycle();
        stepCycle();
        rst_n = 1;

        $display("[TB] I refill latency with tx_done three cycles after accept");
        line_a = randLine();
        mem_rdata = line_a;
        i_addr = 32'h1000_0044; i_req = 1; ready = 1;
        edges = 0; seen = 0; cnt = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tx_done = (k == 4);
            stepCycle();
            edges++;
            if (mem_req) begin
                checkOutput("lat_addr", mem_addr, 32'h1000_0040);
                checkOutput("lat_we", mem_we, 1'b0);
            end
            if (i_done) begin
                seen = 1; cnt++;
                checkOutput("lat_rdata", i_rdata, line_a);
            end
        end
        checkOutput("lat_cycles", edges + 1, 6);
        i_req = 0; tx_done = 0;
        for (int k = 0; k < 4; k++) begin
            stepCycle();
            if (i_done) cnt++;
        end
        checkOutput("lat_done_once", cnt, 1);

        $display("[TB] simultaneous requests");
        tx_done = 1;
        i_req = 1; d_req = 1; i_addr = $urandom; d_addr = $urandom;
        runUntilDone("both1", got_d);
        checkOutput("both_first_d", got_d, 1'b1);
        d_req = 0;
        runUntilDone("both2", got_d);
        checkOutput("both_second_i", got_d, 1'b0);
        i_req = 0;
        stepCycle();

        $display("[TB] starvation guard");
        i_req = 1; d_req = 1;
        for (int g = 0; g < 10; g++) begin
            runUntilDone("starve", got_d);
            checkOutput($sformatf("starve_order%0d", g), got_d, (g % 5) != 4);
            d_addr = $urandom; i_addr = $urandom;
        end
        i_req = 0; d_req = 0;
        stepCycle();

        $display("[TB] D writeback with inputs changed after grant");
        for (int w = 0; w < DEF_LINE_WORDS; w++) incr[32*w +: 32] = 32'h0101_0000 + 32'(w);
        prev_d = m_drdata;
        d_req = 1; d_we = 1; d_wdata = incr; d_addr = 32'h2000_0080;
        stepCycle();
        d_wdata = ~incr; d_we = 0; d_addr = 32'hdead_beef;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (mem_req) begin
                checkOutput("wb_we", mem_we, 1'b1);
                checkOutput("wb_wdata", mem_wdata, incr);
                checkOutput("wb_addr", mem_addr, 32'h2000_0080);
            end
            if (d_done) seen = 1;
            else stepCycle();
        end
        checkOutput("wb_done", seen, 1'b1);
        checkOutput("wb_rdata_kept", d_rdata, prev_d);
        d_req = 0;
        stepCycle();

        $display("[TB] reset during WAIT then stray tx_done");
        tx_done = 0; d_req = 1; d_addr = 32'h3000_0000;
        stepCycle();
        stepCycle();
        stepCycle();
        d_req = 0; rst_n = 0;
        stepCycle();
        rst_n = 1; tx_done = 1;
        stepCycle();
        tx_done = 0;
        for (int k = 0; k < 4; k++) begin
            stepCycle();
            checkOutput("rstwait_ctrl", {i_gnt, d_gnt, i_done, d_done, mem_req, mem_we, err}, '0);
            checkOutput("rstwait_addr", mem_addr, '0);
        end

        $display("[TB] withheld tx_done");
        d_req = 1; ready = 1; tx_done = 0;
`ifdef CACHE_ARB_TIMEOUT_EN
        edges = 0; seen = 0;
        for (int k = 0; k < 60 && !seen; k++) begin
            stepCycle();
            edges++;
            if (d_done) begin
                seen = 1;
                checkOutput("to_err_done", {err, d_done}, 2'b11);
            end
        end
        checkOutput("to_cycles", edges, 18);
        d_req = 0;
        stepCycle();
`else
        cnt = 0;
        for (int k = 0; k < 100; k++) begin
            stepCycle();
            if (d_done || err) cnt++;
        end
        checkOutput("nowait_done", cnt, 0);
        checkOutput("nowait_gnt", d_gnt, 1'b1);
        d_req = 0; rst_n = 0;
        stepCycle();
        rst_n = 1;
`endif

        $display("[TB] randomized traffic");
        for (int c = 0; c < 3000; c++) begin
            applyStimulus();
            stepCycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
